adder_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined `adder` (valid/ready, in-order, fixed latency) between `NUM_REQ` independent requesters. It sits between the requester streams and the adder's input and output handshakes. It tags every issued operation with its requester index in an ordered ID FIFO and routes each returning sum to the requester that issued it. It caps in-flight operations at `MAX_OUTSTANDING`.

---
 rtl/adder_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_adder_rr_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
// Round-robin front end that shares one in-order, fixed-latency adder between NUM_REQ requesters.
// Each issued operation is tagged with its requester index, and each returning sum is steered back to that requester.
module adder_rr_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int DATAW           = 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNTW           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*DATAW-1:0] req_dataa_i,
  input  logic [NUM_REQ*DATAW-1:0] req_datab_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [DATAW-1:0]         rsp_sum_o,
  output logic                     add_valid_o,
  output logic [DATAW-1:0]         add_dataa_o,
  output logic [DATAW-1:0]         add_datab_o,
  input  logic                     add_ready_i,
  input  logic                     add_valid_i,
  input  logic [DATAW-1:0]         add_sum_i,
  output logic                     add_ready_o,
  output logic [CNTW-1:0]          outstanding_o,
  output logic                     err_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [IDW-1:0]  LAST_REQ  = IDW'(NUM_REQ - 1);
  localparam logic [PW-1:0]   LAST_SLOT = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(MAX_OUTSTANDING);

  logic [IDW-1:0]  ptr_r;
  logic [IDW-1:0]  fifo_r [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CNTW-1:0] count_r;
  logic            err_r;

  logic [IDW-1:0]  grant_s;
  logic [IDW-1:0]  head_s;
  logic            full_s;
  logic            empty_s;
  logic            any_valid_s;
  logic            push_s;
  logic            pop_s;

  // First valid requester at or after start, searching circularly; start itself when none is valid.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDW-1:0]     start);
    logic [IDW-1:0] pick;
    int             idx;
    pick = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx  = (int'(start) + k) % NUM_REQ;
      pick = valid[idx] ? IDW'(idx) : pick;
    end
    return pick;
  endfunction

  function automatic logic [IDW-1:0] next_req(input logic [IDW-1:0] r);
    return (r == LAST_REQ) ? {IDW{1'b0}} : r + IDW'(1);
  endfunction

  function automatic logic [PW-1:0] next_slot(input logic [PW-1:0] s);
    return (s == LAST_SLOT) ? {PW{1'b0}} : s + PW'(1);
  endfunction

  assign full_s        = (count_r == FULL_CNT);
  assign empty_s       = (count_r == {CNTW{1'b0}});
  assign any_valid_s   = |req_valid_i;
  assign head_s        = fifo_r[rd_ptr_r];
  assign push_s        = add_valid_o && add_ready_i;
  assign pop_s         = add_valid_i && add_ready_o;
  assign rsp_sum_o     = add_sum_i;
  assign outstanding_o = count_r;
  assign err_o         = err_r;

  // Combinational grant from the round-robin pointer.
  always_comb begin
    grant_s = rr_pick(req_valid_i, ptr_r);
  end

  // Handshake steering on both adder sides; every valid/ready is held low during reset.
  always_comb begin
    add_valid_o = 1'b0;
    add_ready_o = 1'b0;
    req_ready_o = {NUM_REQ{1'b0}};
    rsp_valid_o = {NUM_REQ{1'b0}};
    add_dataa_o = req_dataa_i[int'(grant_s)*DATAW +: DATAW];
    add_datab_o = req_datab_i[int'(grant_s)*DATAW +: DATAW];
    if (!rst_i) begin
      add_valid_o          = any_valid_s && !full_s;
      req_ready_o[grant_s] = add_ready_i && !full_s;
      rsp_valid_o[head_s]  = add_valid_i && !empty_s;
      add_ready_o          = rsp_ready_i[head_s] && !empty_s;
    end else begin
      add_valid_o = 1'b0;
      add_ready_o = 1'b0;
    end
  end

  // Round-robin pointer, ID FIFO pointers/occupancy and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_r    <= {IDW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CNTW{1'b0}};
      err_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= next_slot(wr_ptr_r);
        ptr_r    <= next_req(grant_s);
      end
      if (pop_s) begin
        rd_ptr_r <= next_slot(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNTW'(1);
        2'b01:   count_r <= count_r - CNTW'(1);
        default: count_r <= count_r;
      endcase
      if (add_valid_i && empty_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // ID storage; entries are only read while counted as occupied, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= grant_s;
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Bench for adder_rr_arbiter: a behavioural 2-cycle adder plus a queue-based reference of the arbiter,
// driven by directed phases and a randomized phase.
module tb_adder_rr_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int MO  = 4;
  localparam int LAT = 2;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_dataa, req_datab;
  logic [W-1:0]   rsp_sum, add_dataa, add_datab, add_sum;
  logic           add_valid_out, add_ready_in, add_valid_in, add_ready_out;
  logic [CW-1:0]  outstanding;
  logic           err;

  adder_rr_arbiter #(.NUM_REQ(N), .DATAW(W), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_dataa_i(req_dataa), .req_datab_i(req_datab),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_sum_o(rsp_sum),
    .add_valid_o(add_valid_out), .add_dataa_o(add_dataa), .add_datab_o(add_datab),
    .add_ready_i(add_ready_in),
    .add_valid_i(add_valid_in), .add_sum_i(add_sum), .add_ready_o(add_ready_out),
    .outstanding_o(outstanding), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    int           due;
  } pend_t;

  // Reference state
  int           ptr_m;
  int           idq[$];
  logic [W-1:0] exp_sum[$];
  bit           err_m;
  pend_t        pend[$];
  int           cyc;
  bit           stray;
  // Logs of what the DUT actually did
  int           iss_log[$];
  int           iss_cyc_log[$];
  int           ret_req_log[$];
  logic [W-1:0] ret_sum_log[$];
  int           ret_cyc_log[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return p;
  endfunction

  function automatic int oh_index(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    req_dataa[k*W +: W] = a;
    req_datab[k*W +: W] = b;
  endtask

  task automatic clear_logs();
    iss_log.delete(); iss_cyc_log.delete();
    ret_req_log.delete(); ret_sum_log.delete(); ret_cyc_log.delete();
  endtask

  // One clock: check outputs against the reference, advance reference and adder model, drive adder output.
  task automatic cycle();
    int           g, h;
    bit           full, empty, av, ear, iss, ret;
    logic [N-1:0] err_rr, erv;
    pend_t        pe;
    #1;
    full  = (idq.size() == MO);
    empty = (idq.size() == 0);
    g     = pick(req_valid, ptr_m);
    av    = !rst && (|req_valid) && !full;
    err_rr = '0;
    if (!rst && add_ready_in && !full) err_rr[g] = 1'b1;
    h   = empty ? 0 : idq[0];
    erv = '0;
    ear = 1'b0;
    if (!rst && !empty) begin
      erv[h] = add_valid_in;
      ear    = rsp_ready[h];
    end
    chk("add_valid", add_valid_out, av);
    chk("req_ready", req_ready, err_rr);
    chk("rsp_valid", rsp_valid, erv);
    chk("add_ready", add_ready_out, ear);
    chk("outstanding", outstanding, idq.size());
    chk("err", err, err_m);
    chk("rsp_sum_pass", rsp_sum, add_sum);
    if (!rst) begin
      chk("add_dataa", add_dataa, req_dataa[g*W +: W]);
      chk("add_datab", add_datab, req_datab[g*W +: W]);
    end
    iss = av && add_ready_in;
    ret = add_valid_in && ear;
    if (add_valid_out && add_ready_in) begin
      iss_log.push_back(oh_index(req_ready));
      iss_cyc_log.push_back(cyc);
      pe.sum = add_dataa + add_datab;
      pe.due = cyc + LAT;
      pend.push_back(pe);
    end
    if (|(rsp_valid & rsp_ready)) begin
      ret_req_log.push_back(oh_index(rsp_valid));
      ret_sum_log.push_back(rsp_sum);
      ret_cyc_log.push_back(cyc);
    end
    if (ret && exp_sum.size() > 0) begin
      chk("ret_sum", rsp_sum, exp_sum[0]);
      void'(exp_sum.pop_front());
      void'(idq.pop_front());
    end
    if (add_valid_in && add_ready_out && !stray && pend.size() > 0) void'(pend.pop_front());
    if (iss) begin
      idq.push_back(g);
      exp_sum.push_back(W'(req_dataa[g*W +: W] + req_datab[g*W +: W]));
      ptr_m = (g + 1) % N;
    end
    if (!rst && add_valid_in && empty) err_m = 1'b1;
    if (rst) begin
      ptr_m = 0; idq.delete(); exp_sum.delete(); pend.delete(); err_m = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (stray) begin
      add_valid_in = 1'b1;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      add_valid_in = 1'b1;
      add_sum      = pend[0].sum;
    end else begin
      add_valid_in = 1'b0;
      add_sum      = W'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic rand_ops();
    for (int k = 0; k < N; k++) set_req(k, W'($urandom), W'($urandom));
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '1; add_ready_in = 1'b1;
    add_valid_in = 1'b0; add_sum = '0; stray = 1'b0; cyc = 0;
    ptr_m = 0; err_m = 1'b0;
    rand_ops();
    @(posedge clk);
    #1;
    do_reset();

    // Single requester: 3+4 returns 7 two cycles later
    clear_logs();
    set_req(0, 8'd3, 8'd4);
    req_valid = 4'b0001;
    cycle();
    drain(4);
    chk("single_iss", iss_log.size(), 1);
    chk("single_ret", ret_sum_log.size(), 1);
    chk("single_sum", (ret_sum_log.size() > 0) ? ret_sum_log[0] : 8'hxx, 8'd7);
    chk("single_req", (ret_req_log.size() > 0) ? ret_req_log[0] : -1, 0);
    chk("single_lat", (ret_cyc_log.size() > 0 && iss_cyc_log.size() > 0) ?
                      ret_cyc_log[0] - iss_cyc_log[0] : -1, LAT);

    // Full contention from reset
    do_reset();
    clear_logs();
    req_valid = '1;
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      cycle();
    end
    drain(4);
    chk("rr_count", iss_log.size(), 12);
    for (int i = 0; i < 12; i++) chk("rr_seq", (i < iss_log.size()) ? iss_log[i] : -1, i % N);

    // Sparse: requesters 1 and 3 with ptr at 2
    do_reset();
    req_valid = 4'b0010;
    cycle();
    clear_logs();
    req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) cycle();
    drain(4);
    chk("sparse_0", (iss_log.size() > 0) ? iss_log[0] : -1, 3);
    chk("sparse_1", (iss_log.size() > 1) ? iss_log[1] : -1, 1);
    chk("sparse_2", (iss_log.size() > 2) ? iss_log[2] : -1, 3);

    // Routing and bit-exact pass-through
    do_reset();
    clear_logs();
    set_req(2, 8'd10, 8'd5);   req_valid = 4'b0100; cycle();
    set_req(0, 8'hFD, 8'hFC);  req_valid = 4'b0001; cycle();
    set_req(1, 8'd127, 8'd1);  req_valid = 4'b0010; cycle();
    drain(4);
    chk("route_n", ret_req_log.size(), 3);
    chk("route_r0", (ret_req_log.size() > 0) ? ret_req_log[0] : -1, 2);
    chk("route_s0", (ret_sum_log.size() > 0) ? ret_sum_log[0] : 8'hxx, 8'd15);
    chk("route_r1", (ret_req_log.size() > 1) ? ret_req_log[1] : -1, 0);
    chk("route_s1", (ret_sum_log.size() > 1) ? ret_sum_log[1] : 8'hxx, 8'hF9);
    chk("route_r2", (ret_req_log.size() > 2) ? ret_req_log[2] : -1, 1);
    chk("route_s2", (ret_sum_log.size() > 2) ? ret_sum_log[2] : 8'hxx, 8'h80);

    // Full with result backpressure, then one pop lets issue resume
    do_reset();
    rsp_ready = '0;
    req_valid = '1;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      cycle();
    end
    chk("full_cnt", outstanding, MO);
    chk("full_av", add_valid_out, 1'b0);
    chk("full_rr", req_ready, 4'b0000);
    rsp_ready = '1;
    cycle();
    rsp_ready = '0;
    chk("resume_cnt", outstanding, MO - 1);
    chk("resume_av", add_valid_out, 1'b1);
    cycle();

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      req_valid    = N'($urandom);
      rsp_ready    = N'($urandom);
      add_ready_in = ($urandom_range(0, 3) != 0);
      rand_ops();
      cycle();
    end
    rsp_ready = '1;
    add_ready_in = 1'b1;
    drain(12);

    // Stray result sets the sticky error; reset clears state and restarts at index 0
    do_reset();
    stray = 1'b1; add_valid_in = 1'b1; add_sum = 8'h5A;
    cycle();
    chk("err_set", err, 1'b1);
    cycle();
    stray = 1'b0; add_valid_in = 1'b0;
    rsp_ready = '0;
    req_valid = '1;
    for (int i = 0; i < 3; i++) cycle();
    req_valid = '0;
    cycle();
    chk("err_hold", err, 1'b1);
    chk("pre_rst_cnt", outstanding, 3);
    req_valid = '1;
    do_reset();
    chk("rst_cnt", outstanding, 0);
    chk("rst_err", err, 1'b0);
    clear_logs();
    rsp_ready = '1;
    cycle();
    chk("rst_grant", (iss_log.size() > 0) ? iss_log[0] : -1, 0);
    drain(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
